// File: rtl/avlmm_in_pkg.sv
// Shared definitions for the Avalon-MM status read-back block.
// Holds the register offsets above the data window, the CTRL bit positions,
// the default pattern returned for unmapped addresses and the address decoder.
// Register map, with Q = number of input words:
//   0..Q-1  DATA[k]  live input or shadow copy, depending on SNAP_MODE
//   Q       CTRL     bit0 SNAP_MODE (RW), bit1 CAPTURE (write-1 pulse, reads 0)
//   Q+1     CHG      sticky per-word change flags, write 1 to clear
//   Q+2     CAPCNT   capture counter, any write clears it
//   above   unmapped, reads the OOR pattern
package avlmm_in_pkg;

   localparam int unsigned OFS_CTRL   = 0;
   localparam int unsigned OFS_CHG    = 1;
   localparam int unsigned OFS_CAPCNT = 2;
   localparam int unsigned NUM_CSR    = 3;

   localparam int CTRL_SNAP_MODE = 0;
   localparam int CTRL_CAPTURE   = 1;

   localparam logic [63:0] OOR_DEFAULT = 64'h0000_0000_BADA_DD00;

   typedef enum logic [2:0] {
      SEL_DATA,
      SEL_CTRL,
      SEL_CHG,
      SEL_CAPCNT,
      SEL_OOR
   } reg_sel_e;

   function automatic reg_sel_e decode_addr(input int unsigned addr,
                                            input int unsigned qty);
      if (addr < qty)                    return SEL_DATA;
      else if (addr == qty + OFS_CTRL)   return SEL_CTRL;
      else if (addr == qty + OFS_CHG)    return SEL_CHG;
      else if (addr == qty + OFS_CAPCNT) return SEL_CAPCNT;
      else                               return SEL_OOR;
   endfunction

endpackage

// File: rtl/avlmm_rd_pipe.sv
// Read-return pipe: delays a read result and its valid flag by LATENCY
// register stages. Data in each stage only moves when that stage carries a
// valid beat, so the output word holds the last returned value between reads.
// Ports:
//   clk          clock, posedge active
//   rst_n        async reset, active low; clears every stage (drops in-flight reads)
//   in_valid_i   read accepted this cycle
//   in_data_i    read value sampled at the accepting edge
//   out_valid_o  returned read valid
//   out_data_o   returned read data
module avlmm_rd_pipe #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   output logic [WIDTH-1:0] out_data_o
);

   logic [LATENCY-1:0] vld_q;
   logic [WIDTH-1:0]   dat_q [LATENCY];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            dat_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= in_valid_i;
         if (in_valid_i) begin
            dat_q[0] <= in_data_i;
         end
         for (int i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
               dat_q[i] <= dat_q[i-1];
            end
         end
      end
   end

   assign out_valid_o = vld_q[LATENCY-1];
   assign out_data_o  = dat_q[LATENCY-1];

endmodule

// File: rtl/avlmm_in_snap.sv
// Avalon-MM read-back block for WORD_QTY status words coming from the fabric.
// Provides live or snapshot reads of the words, sticky change flags with
// write-1-to-clear, a capture counter and a 1- or 2-cycle read latency.
// Ports:
//   clk, rst_n       clock and async active-low reset
//   read, write      Avalon strobes; write wins when both are high
//   address          word address
//   writedata        write data
//   readdata         read data, qualified by readdatavalid, held otherwise
//   readdatavalid    one-cycle pulse per accepted read, READ_LATENCY cycles later
//   waitrequest      always 0, every access completes immediately
//   data_in          packed status words, word k = [k*WORD_WIDTH +: WORD_WIDTH]
//   capture_in       fabric capture strobe, same clock domain
module avlmm_in_snap
   import avlmm_in_pkg::*;
#(
   parameter int          WORD_WIDTH   = 32,
   parameter int          WORD_QTY     = 10,
   parameter int          ADDR_WIDTH   = 4,
   parameter int          READ_LATENCY = 1,
   parameter logic [63:0] OOR_PATTERN  = OOR_DEFAULT
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           read,
   input  logic                           write,
   input  logic [ADDR_WIDTH-1:0]          address,
   input  logic [WORD_WIDTH-1:0]          writedata,
   output logic [WORD_WIDTH-1:0]          readdata,
   output logic                           readdatavalid,
   output logic                           waitrequest,
   input  logic [WORD_QTY*WORD_WIDTH-1:0] data_in,
   input  logic                           capture_in
);

   localparam int W = WORD_WIDTH;
   localparam int Q = WORD_QTY;

   if (WORD_WIDTH < 8 || WORD_WIDTH > 64) begin : g_chk_width
      $error("avlmm_in_snap: WORD_WIDTH must be 8..64");
   end
   if (WORD_QTY < 1 || WORD_QTY > WORD_WIDTH) begin : g_chk_qty
      $error("avlmm_in_snap: WORD_QTY must be 1..WORD_WIDTH");
   end
   if ((2 ** ADDR_WIDTH) < (WORD_QTY + int'(NUM_CSR))) begin : g_chk_addr
      $error("avlmm_in_snap: ADDR_WIDTH too small for WORD_QTY+3 registers");
   end
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_chk_lat
      $error("avlmm_in_snap: READ_LATENCY must be 1 or 2");
   end

   logic [W-1:0]   shadow_q [Q];
   logic [Q*W-1:0] prev_q;
   logic [Q-1:0]   chg_q,    chg_d;
   logic [W-1:0]   capcnt_q, capcnt_d;
   logic           snap_q,   snap_d;

   reg_sel_e       reg_sel;
   logic           wr_ctrl;
   logic           wr_chg;
   logic           wr_capcnt;
   logic           cap_req;
   logic           rd_accept;
   logic [Q-1:0]   chg_set;
   logic [Q-1:0]   chg_clr;
   logic [W-1:0]   rd_data;
   logic           unused_wdata;

   assign waitrequest = 1'b0;

   // CHG only consumes the low Q bits of writedata and CTRL only two bits.
   assign unused_wdata = ^writedata;

   assign reg_sel   = decode_addr(32'(address), Q);
   assign wr_ctrl   = write && (reg_sel == SEL_CTRL);
   assign wr_chg    = write && (reg_sel == SEL_CHG);
   assign wr_capcnt = write && (reg_sel == SEL_CAPCNT);

   // Both capture sources in the same cycle merge into a single capture.
   assign cap_req   = capture_in || (wr_ctrl && writedata[CTRL_CAPTURE]);

   // A simultaneous write turns the read into a no-op.
   assign rd_accept = read && !write;

   always_comb begin
      for (int k = 0; k < Q; k++) begin
         chg_set[k] = (data_in[k*W +: W] != prev_q[k*W +: W]);
      end
   end

   assign chg_clr = wr_chg ? writedata[Q-1:0] : '0;

   // Applying the set after the clear lets a new change win over a W1C.
   assign chg_d = (chg_q & ~chg_clr) | chg_set;

   always_comb begin
      capcnt_d = capcnt_q;
      if (wr_capcnt) begin
         capcnt_d = cap_req ? W'(1) : '0;
      end else if (cap_req) begin
         capcnt_d = capcnt_q + W'(1);
      end
   end

   assign snap_d = wr_ctrl ? writedata[CTRL_SNAP_MODE] : snap_q;

   // Read mux works on pre-edge register values, so a read that coincides
   // with a capture or a W1C returns the old shadow or the old flags.
   always_comb begin
      rd_data = OOR_PATTERN[W-1:0];
      case (reg_sel)
         SEL_DATA: begin
            for (int k = 0; k < Q; k++) begin
               if (address == ADDR_WIDTH'(k)) begin
                  rd_data = snap_q ? shadow_q[k] : data_in[k*W +: W];
               end
            end
         end
         SEL_CTRL: begin
            rd_data                 = '0;
            rd_data[CTRL_SNAP_MODE] = snap_q;
         end
         SEL_CHG:    rd_data = W'(chg_q);
         SEL_CAPCNT: rd_data = capcnt_q;
         default:    rd_data = OOR_PATTERN[W-1:0];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < Q; k++) begin
            shadow_q[k] <= '0;
         end
         prev_q   <= '0;
         chg_q    <= '0;
         capcnt_q <= '0;
         snap_q   <= 1'b0;
      end else begin
         if (cap_req) begin
            for (int k = 0; k < Q; k++) begin
               shadow_q[k] <= data_in[k*W +: W];
            end
         end
         prev_q   <= data_in;
         chg_q    <= chg_d;
         capcnt_q <= capcnt_d;
         snap_q   <= snap_d;
      end
   end

   avlmm_rd_pipe #(
      .WIDTH   (W),
      .LATENCY (READ_LATENCY)
   ) u_rd_pipe (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (rd_accept),
      .in_data_i   (rd_data),
      .out_valid_o (readdatavalid),
      .out_data_o  (readdata)
   );

endmodule

// File: tb/tb_avlmm_in_snap.sv
module tb_avlmm_in_snap;

   localparam int W  = 16;
   localparam int Q  = 10;
   localparam int AW = 4;
   localparam int RL = 2;
   localparam logic [63:0] OOR_FULL = 64'hBADADD00;
   localparam logic [W-1:0] OOR_EXP = OOR_FULL[W-1:0];

   logic             clk = 1'b0;
   logic             rst_n;
   logic             read;
   logic             write;
   logic [AW-1:0]    address;
   logic [W-1:0]     writedata;
   logic [W-1:0]     readdata;
   logic             readdatavalid;
   logic             waitrequest;
   logic [Q*W-1:0]   data_in;
   logic             capture_in;

   int n_checks = 0;
   int n_err    = 0;
   bit cmp_en   = 0;

   avlmm_in_snap #(
      .WORD_WIDTH   (W),
      .WORD_QTY     (Q),
      .ADDR_WIDTH   (AW),
      .READ_LATENCY (RL),
      .OOR_PATTERN  (OOR_FULL)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .read          (read),
      .write         (write),
      .address       (address),
      .writedata     (writedata),
      .readdata      (readdata),
      .readdatavalid (readdatavalid),
      .waitrequest   (waitrequest),
      .data_in       (data_in),
      .capture_in    (capture_in)
   );

   always #5 clk = ~clk;

   // Behavioural model: register contents plus a queue of pending read
   // returns tagged with the edge number at which they must appear.
   typedef struct {
      longint       due;
      logic [W-1:0] data;
   } pend_t;

   logic [W-1:0]   m_shadow [Q];
   logic [Q*W-1:0] m_prev;
   logic [Q-1:0]   m_chg;
   logic [W-1:0]   m_capcnt;
   bit             m_snap;
   pend_t          pend [$];
   longint         cyc = 0;
   bit             exp_valid;
   logic [W-1:0]   exp_data;

   task automatic model_reset();
      for (int k = 0; k < Q; k++) m_shadow[k] = '0;
      m_prev    = '0;
      m_chg     = '0;
      m_capcnt  = '0;
      m_snap    = 0;
      pend.delete();
      exp_valid = 0;
      exp_data  = '0;
   endtask

   // Advance one clock: evaluate the model against the inputs that the DUT
   // samples at the coming edge, wait for that edge, then publish expectations.
   task automatic tick();
      int           a;
      bit           cap;
      logic [W-1:0] rv;
      pend_t        p;
      a = int'(address);
      if (rst_n) begin
         if (read && !write) begin
            if (a < Q)          rv = m_snap ? m_shadow[a] : data_in[a*W +: W];
            else if (a == Q)    rv = W'(m_snap);
            else if (a == Q+1)  rv = W'(m_chg);
            else if (a == Q+2)  rv = m_capcnt;
            else                rv = OOR_EXP;
            pend.push_back('{due: cyc + RL, data: rv});
         end
         cap = capture_in || (write && a == Q && writedata[1]);
         if (write && a == Q+1) m_chg = m_chg & ~writedata[Q-1:0];
         for (int k = 0; k < Q; k++) begin
            if (data_in[k*W +: W] != m_prev[k*W +: W]) m_chg[k] = 1'b1;
         end
         if (write && a == Q+2) m_capcnt = cap ? W'(1) : '0;
         else if (cap)          m_capcnt = m_capcnt + W'(1);
         if (write && a == Q)   m_snap = writedata[0];
         if (cap) begin
            for (int k = 0; k < Q; k++) m_shadow[k] = data_in[k*W +: W];
         end
         m_prev = data_in;
      end
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         model_reset();
      end else begin
         exp_valid = 0;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            p         = pend.pop_front();
            exp_valid = 1;
            exp_data  = p.data;
         end
      end
      #1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            n_checks++;
            if (readdatavalid !== exp_valid) begin
               n_err++;
               $display("FAIL rdvalid @%0t: got %0b exp %0b", $time, readdatavalid, exp_valid);
            end
            n_checks++;
            if (readdata !== exp_data) begin
               n_err++;
               $display("FAIL rddata @%0t: got %h exp %h", $time, readdata, exp_data);
            end
            n_checks++;
            if (waitrequest !== 1'b0) begin
               n_err++;
               $display("FAIL waitreq @%0t: got %0b exp 0", $time, waitrequest);
            end
         end
      end
   end

   task automatic set_word(input int k, input logic [W-1:0] v);
      data_in[k*W +: W] = v;
   endtask

   task automatic do_write(input int a, input logic [W-1:0] d);
      write = 1; address = AW'(a); writedata = d;
      tick();
      write = 0;
   endtask

   task automatic do_read(input int a, input logic [W-1:0] exp, input string name);
      int lat;
      read = 1; address = AW'(a);
      tick();
      read = 0;
      lat = 1;
      while (!readdatavalid && lat < 6) begin
         tick();
         lat++;
      end
      n_checks++;
      if (!readdatavalid || lat != RL || readdata !== exp) begin
         n_err++;
         $display("FAIL %s: got %h (valid %0b, latency %0d) exp %h (latency %0d)",
                  name, readdata, readdatavalid, lat, exp, RL);
      end
      tick();
   endtask

   initial begin
      int           nv, first, last, cnt;
      logic [W-1:0] got [4];
      logic [W-1:0] w2;

      read = 0; write = 0; address = '0; writedata = '0;
      data_in = '0; capture_in = 0; rst_n = 0;
      model_reset();
      tick();
      cmp_en = 1;
      tick();
      rst_n = 1;
      tick();

      // Reset values of the whole map
      for (int a = 0; a < Q+3; a++) do_read(a, '0, $sformatf("rst_addr%0d", a));
      do_read(Q+3, OOR_EXP, "oor");

      // Live read and change flag
      set_word(3, 16'h1234);
      tick();
      do_read(3, 16'h1234, "live_word3");
      do_read(Q+1, 16'h0008, "chg_bit3");
      do_write(Q+1, 16'h0008);
      do_read(Q+1, 16'h0000, "chg_w1c");

      // Snapshot via CTRL.CAPTURE
      do_write(Q, 16'h0001);
      set_word(0, 16'h000A);
      tick();
      do_write(Q, 16'h0003);
      set_word(0, 16'h000B);
      tick();
      do_read(0, 16'h000A, "snap_word0");
      do_read(Q+2, 16'h0001, "capcnt_one");
      do_read(Q, 16'h0001, "ctrl_readback");

      // Coincident captures count once; write+capture gives 1; wrap
      capture_in = 1; write = 1; address = AW'(Q); writedata = 16'h0003;
      tick();
      capture_in = 0; write = 0;
      do_read(Q+2, 16'h0002, "cap_both_once");
      capture_in = 1; write = 1; address = AW'(Q+2); writedata = 16'h5A5A;
      tick();
      capture_in = 0; write = 0;
      do_read(Q+2, 16'h0001, "capcnt_wr_cap");
      do_write(Q+2, 16'h0000);
      capture_in = 1;
      repeat (65535) tick();
      capture_in = 0;
      do_read(Q+2, 16'hFFFF, "capcnt_max");
      capture_in = 1;
      tick();
      capture_in = 0;
      do_read(Q+2, 16'h0000, "capcnt_wrap");

      // Set beats clear in the same cycle
      do_write(Q+1, 16'hFFFF);
      w2 = data_in[2*W +: W] ^ 16'h00FF;
      set_word(2, w2);
      write = 1; address = AW'(Q+1); writedata = 16'h0004;
      tick();
      write = 0;
      do_read(Q+1, 16'h0004, "chg_set_wins");

      // Back-to-back reads return in order, one per cycle
      do_write(Q, 16'h0000);
      for (int k = 0; k < 4; k++) set_word(k, W'(16'h1000 + k));
      tick();
      nv = 0; first = -1; last = -1;
      for (int i = 0; i < 10; i++) begin
         if (i < 4) begin read = 1; address = AW'(i); end
         else read = 0;
         tick();
         if (readdatavalid) begin
            if (nv < 4) got[nv] = readdata;
            if (first < 0) first = i;
            last = i;
            nv++;
         end
      end
      n_checks++;
      if (nv != 4 || first != RL-1 || last - first != 3) begin
         n_err++;
         $display("FAIL b2b_valids: got count %0d first %0d last %0d exp 4 %0d %0d",
                  nv, first, last, RL-1, RL+2);
      end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (got[k] !== W'(16'h1000 + k)) begin
            n_err++;
            $display("FAIL b2b_data%0d: got %h exp %h", k, got[k], W'(16'h1000 + k));
         end
      end

      // Reset with a read in flight
      data_in = '0;
      set_word(5, 16'h0055);
      tick(); tick();
      read = 1; address = AW'(3);
      tick();
      read = 0;
      rst_n = 0;
      model_reset();
      cnt = 0;
      repeat (3) begin
         tick();
         if (readdatavalid) cnt++;
      end
      rst_n = 1;
      repeat (4) begin
         tick();
         if (readdatavalid) cnt++;
      end
      n_checks++;
      if (cnt != 0) begin
         n_err++;
         $display("FAIL inflight_drop: got %0d valids exp 0", cnt);
      end
      do_read(Q, 16'h0000, "ctrl_after_rst");
      do_read(Q+2, 16'h0000, "capcnt_after_rst");
      do_read(Q+1, 16'h0020, "chg_after_rst");
      do_write(Q, 16'h0001);
      do_read(5, 16'h0000, "shadow_after_rst");

      // Randomised traffic against the model
      for (int it = 0; it < 3000; it++) begin
         int k;
         read       = ($urandom_range(0, 99) < 45);
         write      = ($urandom_range(0, 99) < 20);
         address    = AW'($urandom_range(0, 15));
         if (write && $urandom_range(0, 3) != 0) address = AW'(Q + $urandom_range(0, 2));
         writedata  = W'($urandom);
         capture_in = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 9) == 0) begin
            k = $urandom_range(0, Q-1);
            set_word(k, W'($urandom));
         end
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 0;
            model_reset();
            tick();
            rst_n = 1;
         end
         tick();
      end
      read = 0; write = 0; capture_in = 0;
      repeat (5) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
